// File: rtl/chunked_addsub_pkg.sv
// Shared definitions for the chunked add/sub datapath: operation select
// encoding, FSM state type and the per-bit full-adder helper.
package chunked_addsub_pkg;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Returns {carry_out, sum} for one bit position.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

  // Index counter width; a single-chunk configuration still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_addsub_if.sv
// Request/result bundle between a requester and the chunked add/sub unit.
interface chunked_addsub_if #(
  parameter int WIDTH = 16
) ();

  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             sel;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output start, x, y, sel,
    input  ready, busy, done, sum, c_out, overflow, zero, negative
  );

  modport slave (
    input  start, x, y, sel,
    output ready, busy, done, sum, c_out, overflow, zero, negative
  );

endinterface

// File: rtl/chunked_addsub_chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from per-bit full adders; also
// exposes the carry into its top bit so the caller can form signed overflow.
module chunked_addsub_chunk_adder
  import chunked_addsub_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic carry_s;

  // Ripple through the lower bits, capture the carry into the top bit, then finish.
  always_comb begin
    s       = '0;
    carry_s = cin;
    for (int i = 0; i < CHUNK - 1; i++) begin
      {carry_s, s[i]} = full_add(a[i], b[i], carry_s);
    end
    cmsb = carry_s;
    {carry_s, s[CHUNK-1]} = full_add(a[CHUNK-1], b[CHUNK-1], carry_s);
    cout = carry_s;
  end

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock through a
// registered carry, with start/ready/done handshake and registered flags.
module chunked_addsub
  import chunked_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic           clk,
  input  logic           reset,
  chunked_addsub_if.slave bus
);

  generate
    if ((CHUNK < 1) || (WIDTH < 2) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
      $error("chunked_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  localparam int                NCHUNK   = WIDTH / CHUNK;
  localparam int                IDX_W    = idx_width(NCHUNK);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NCHUNK - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             accept_s;
  logic             last_s;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_full_s;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;

  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;
  logic [CHUNK-1:0] s_chunk_s;
  logic             c_chunk_s;
  logic             cmsb_s;

  logic             ready_r;
  logic             busy_r;
  logic             done_r;
  logic             c_out_r;
  logic             overflow_r;
  logic             zero_r;
  logic             negative_r;

  assign last_s = (idx_r == LAST_IDX);

  // Select the active chunk and splice its result into the running sum.
  always_comb begin
    a_chunk_s  = a_r[idx_r*CHUNK +: CHUNK];
    b_chunk_s  = b_r[idx_r*CHUNK +: CHUNK];
    sum_full_s = sum_r;
    sum_full_s[idx_r*CHUNK +: CHUNK] = s_chunk_s;
  end

  chunked_addsub_chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a    (a_chunk_s),
    .b    (b_chunk_s),
    .cin  (carry_r),
    .s    (s_chunk_s),
    .cout (c_chunk_s),
    .cmsb (cmsb_s)
  );

  // Next-state and accept decode; DONE can accept back-to-back.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = ST_RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_nxt_s = ST_RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        accept_s    = 1'b0;
      end
    endcase
  end

  // State register with handshake outputs registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_DONE);
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Operand capture on accept, one chunk per RUN edge, flags on the final chunk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r        <= '0;
      b_r        <= '0;
      sum_r      <= '0;
      idx_r      <= '0;
      carry_r    <= 1'b0;
      c_out_r    <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b0;
      negative_r <= 1'b0;
    end else if (accept_s) begin
      // Subtraction is x + ~y + 1: invert B here and seed the carry with sel.
      a_r     <= bus.x;
      b_r     <= bus.y ^ {WIDTH{bus.sel}};
      carry_r <= (bus.sel == SEL_SUB);
      idx_r   <= '0;
    end else if (state_r == ST_RUN) begin
      sum_r   <= sum_full_s;
      carry_r <= c_chunk_s;
      idx_r   <= last_s ? '0 : idx_r + IDX_W'(1);
      if (last_s) begin
        c_out_r    <= c_chunk_s;
        overflow_r <= c_chunk_s ^ cmsb_s;
        zero_r     <= (sum_full_s == '0);
        negative_r <= sum_full_s[WIDTH-1];
      end
    end
  end

  assign bus.ready    = ready_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.sum      = sum_r;
  assign bus.c_out    = c_out_r;
  assign bus.overflow = overflow_r;
  assign bus.zero     = zero_r;
  assign bus.negative = negative_r;

endmodule

// File: tb/tb_chunked_addsub.sv
// Self-checking bench for chunked_addsub (WIDTH=16, CHUNK=4): directed table,
// random operations against an arithmetic model, and handshake/reset sequences.
module tb_chunked_addsub;
  import chunked_addsub_pkg::*;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        sel;
    logic [15:0] sum;
    logic        c;
    logic        o;
    logic        z;
    logic        n;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  chunked_addsub_if #(.WIDTH(WIDTH)) bus ();

  chunked_addsub #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference built from plain integer arithmetic.
  function automatic vec_t ref_model(input logic [15:0] xa, input logic [15:0] ya, input logic s);
    vec_t        v;
    int          sx;
    int          sy;
    int          r;
    logic [16:0] u;
    sx = int'($signed(xa));
    sy = int'($signed(ya));
    v.x = xa;
    v.y = ya;
    v.sel = s;
    if (s == SEL_SUB) begin
      v.sum = xa - ya;
      v.c   = (xa >= ya);
      r     = sx - sy;
    end else begin
      u     = {1'b0, xa} + {1'b0, ya};
      v.sum = u[15:0];
      v.c   = u[16];
      r     = sx + sy;
    end
    v.o = (r > 32767) || (r < -32768);
    v.z = (v.sum == 16'h0000);
    v.n = v.sum[15];
    return v;
  endfunction

  task automatic chk_result(input string tag, input vec_t v);
    chk({tag, " sum"},      {16'h0000, bus.sum},  {16'h0000, v.sum});
    chk({tag, " c_out"},    {31'd0, bus.c_out},    {31'd0, v.c});
    chk({tag, " overflow"}, {31'd0, bus.overflow}, {31'd0, v.o});
    chk({tag, " zero"},     {31'd0, bus.zero},     {31'd0, v.z});
    chk({tag, " negative"}, {31'd0, bus.negative}, {31'd0, v.n});
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic accept_op(input logic [15:0] xa, input logic [15:0] ya, input logic s);
    int n = 0;
    while (!bus.ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready before start", {31'd0, bus.ready}, 32'd1);
    bus.start = 1'b1;
    bus.x     = xa;
    bus.y     = ya;
    bus.sel   = s;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.x     = 16'($urandom);
    bus.y     = 16'($urandom);
    bus.sel   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int lat0, output int lat, output int busy_cnt);
    lat      = lat0;
    busy_cnt = 0;
    while (!bus.done && lat < 30) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    chk("done seen", {31'd0, bus.done}, 32'd1);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    int bc;
    accept_op(v.x, v.y, v.sel);
    wait_done(1, lat, bc);
    chk({tag, " latency"}, lat, NCHUNK + 1);
    chk({tag, " busy cycles"}, bc, NCHUNK);
    chk({tag, " ready in done"}, {31'd0, bus.ready}, 32'd1);
    chk_result(tag, v);
    @(negedge clk);
    chk({tag, " done one cycle"}, {31'd0, bus.done}, 32'd0);
    chk({tag, " sum held"}, {16'h0000, bus.sum}, {16'h0000, v.sum});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ready"},    {31'd0, bus.ready},    32'd1);
    chk({tag, " busy"},     {31'd0, bus.busy},     32'd0);
    chk({tag, " done"},     {31'd0, bus.done},     32'd0);
    chk({tag, " sum"},      {16'h0000, bus.sum},   32'd0);
    chk({tag, " c_out"},    {31'd0, bus.c_out},    32'd0);
    chk({tag, " overflow"}, {31'd0, bus.overflow}, 32'd0);
    chk({tag, " zero"},     {31'd0, bus.zero},     32'd0);
    chk({tag, " negative"}, {31'd0, bus.negative}, 32'd0);
  endtask

  vec_t vecs [8];

  initial begin
    vec_t v;
    int   lat;
    int   bc;
    int   t1;
    int   t2;
    int   n;
    logic seen;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};

    bus.start = 1'b0;
    bus.x     = 16'h0000;
    bus.y     = 16'h0000;
    bus.sel   = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    for (int i = 0; i < 40; i++) begin
      v = ref_model(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      run_vec($sformatf("rand%0d", i), v);
    end

    // start pulsed during RUN with different operands must be ignored
    accept_op(16'h1234, 16'h0FFF, SEL_ADD);
    bus.start = 1'b1;
    bus.x     = 16'hAAAA;
    bus.y     = 16'h5555;
    bus.sel   = SEL_SUB;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(2, lat, bc);
    chk("ignore-start latency", lat, NCHUNK + 1);
    chk_result("ignore-start", ref_model(16'h1234, 16'h0FFF, SEL_ADD));
    @(negedge clk);

    // start held high through DONE: back-to-back operations 5 cycles apart
    bus.start = 1'b1;
    bus.x     = 16'h0100;
    bus.y     = 16'h0200;
    bus.sel   = SEL_ADD;
    @(posedge clk);
    @(negedge clk);
    bus.x   = 16'h0005;
    bus.y   = 16'h0007;
    bus.sel = SEL_SUB;
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("held-start first done", {31'd0, bus.done}, 32'd1);
    t1 = cyc;
    chk_result("held-start op1", ref_model(16'h0100, 16'h0200, SEL_ADD));
    @(negedge clk);
    bus.start = 1'b0;
    chk("held-start reaccepted busy", {31'd0, bus.busy}, 32'd1);
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("held-start second done", {31'd0, bus.done}, 32'd1);
    t2 = cyc;
    chk("done spacing", t2 - t1, NCHUNK + 1);
    chk_result("held-start op2", ref_model(16'h0005, 16'h0007, SEL_SUB));
    @(negedge clk);

    // reset after chunk 2 of an operation: abandoned, no done pulse
    accept_op(16'h1234, 16'h0FFF, SEL_ADD);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    chk("midreset held done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | bus.done;
    end
    chk("no done after reset", {31'd0, seen}, 32'd0);
    run_vec("post-reset", ref_model(16'h0001, 16'h0001, SEL_ADD));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
